// File: rtl/serial_magnitude_ctrl_pkg.sv
// Shared types and constants for the nibble-serial magnitude comparator.
// Result codes are one-hot in {gt, lt, eq} order, matching the output flags.
package serial_magnitude_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;

endpackage

// File: rtl/serial_magnitude_ctrl_nibble_cmp.sv
// Purely combinational 4-bit unsigned comparator shared by every step of a
// wide compare.
module nibble_cmp
  import serial_magnitude_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/serial_magnitude_ctrl.sv
// Wide unsigned compare done one nibble per clock, MSB nibble first, with an
// early exit at the first differing nibble and a start/busy/done handshake.
module serial_magnitude_ctrl
  import serial_magnitude_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [4*NIBBLES-1:0]     a,
  input  logic [4*NIBBLES-1:0]     b,
  output logic                     busy,
  output logic                     done,
  output logic                     a_greater_b,
  output logic                     a_lesser_b,
  output logic                     a_equal_b
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBBLES - 1);

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [IDX_W-1:0] idx;
  logic [2:0]       res_q;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic             nib_gt;
  logic             nib_lt;
  logic             nib_eq;
  logic [2:0]       nib_res;

  // Only the selected nibble reaches the single shared comparator.
  assign a_nib = a_q[NIB_W*int'(idx) +: NIB_W];
  assign b_nib = b_q[NIB_W*int'(idx) +: NIB_W];

  nibble_cmp u_nibble_cmp (
    .a  (a_nib),
    .b  (b_nib),
    .gt (nib_gt),
    .lt (nib_lt),
    .eq (nib_eq)
  );

  // NOTE: assign a default first so every path drives nib_res and no latch is inferred.
  always_comb begin
    nib_res = RES_EQ;
    if (nib_gt)      nib_res = RES_GT;
    else if (nib_lt) nib_res = RES_LT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      res_q <= RES_NONE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= CMP;
            a_q   <= a;
            b_q   <= b;
            idx   <= IDX_TOP;
            res_q <= RES_NONE;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        CMP: begin
          // A differing nibble, or equality down to nibble 0, ends the compare.
          if (!nib_eq || (idx == '0)) begin
            res_q <= nib_res;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign {a_greater_b, a_lesser_b, a_equal_b} = res_q;

endmodule

// File: doc/serial_magnitude_ctrl.md
# serial_magnitude_ctrl

Sequential controller that compares two wide unsigned operands one 4-bit nibble per clock, most-significant nibble first, using a single 4-bit comparator. It exits early at the first unequal nibble. Results are reported through a start/busy/done handshake. It lets wide compares share one small comparator instead of a full-width one, and sits between a requesting datapath and that comparator.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; operand width W = 4*NIBBLES; legal range 1..16.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request a compare; accepted only when `busy`=0.
- `a`, in, W: operand A, unsigned; sampled on the accepted `start`.
- `b`, in, W: operand B, unsigned; sampled on the accepted `start`.
- `busy`, out, 1: compare in progress; `start` is ignored while high.
- `done`, out, 1: one-cycle pulse; the result outputs are valid from this cycle on.
- `a_greater_b`, out, 1: registered result flag.
- `a_lesser_b`, out, 1: registered result flag.
- `a_equal_b`, out, 1: registered result flag.

## Operation
- FSM states: IDLE, CMP, DONE.
- **IDLE → CMP** on `start`=1.
  - Latch `a` and `b` into operand registers.
  - Nibble index `idx` = NIBBLES-1.
  - Clear all three result flags.
- **CMP**: compare `a_q[4*idx+:4]` with `b_q[4*idx+:4]`.
  - Nibbles unequal: set exactly one of `a_greater_b` / `a_lesser_b`, then go to DONE.
  - Nibbles equal and `idx`=0: set `a_equal_b`, then go to DONE.
  - Nibbles equal and `idx`>0: decrement `idx`, stay in CMP.
- **DONE**: `done`=1 for this single cycle.
  - `start`=1 here behaves as in IDLE (back-to-back compare accepted).
  - Otherwise go to IDLE.
- Result flags are one-hot whenever `done` has fired. They hold until the next accepted `start` clears them.
- `busy` = 1 exactly in CMP.
- `start` in CMP is ignored: operands, `idx` and results are unaffected, and nothing is queued.
- Operands are unsigned. `idx` is $clog2(NIBBLES) bits, minimum 1 bit. NIBBLES=1 gives a single CMP cycle.
- `a` and `b` are don't-care except in the cycle `start` is accepted.

## Timing
- Reset:
  - State IDLE.
  - `busy`=0, `done`=0, all three result flags 0.
  - Operand registers and `idx` are 0.
- Reset asserted mid-compare aborts it: no `done` and no result; the block is back in IDLE the cycle after `rst` is released.
- `start` accepted at edge T. CMP occupies cycles T+1 .. T+k, where k = number of nibbles examined (1..NIBBLES). `done` and the results are visible at T+k+1.
- Latency bounds: best case is 2 cycles from `start` to `done` (MSB nibble differs). Worst case is NIBBLES+1 cycles (equal operands, or only the LSB nibble differs).
- Throughput: one new compare may be accepted in the DONE cycle. The minimum start-to-start spacing is k+1 cycles.
- `rst` and `start` in the same cycle: `rst` wins.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package contents:
  - FSM state enum (IDLE/CMP/DONE).
  - Nibble width constant NIB_W=4.
  - Result encoding constants RES_GT, RES_LT, RES_EQ, used for the internal one-hot-to-flag mapping.
- Sub-module `nibble_cmp`: purely combinational 4-bit unsigned compare producing gt/lt/eq. Instantiated once; the controller only muxes the selected nibble into it.
- Controller body: FSM, operand registers, `idx` counter, result registers.

## Test plan
All cases use NIBBLES=4; T is the edge at which `start` is accepted.
- Equal operands: `a`=16'h1234, `b`=16'h1234, start at T → `busy` high T+1..T+4; `done` at T+5 with `a_equal_b`=1, other flags 0.
- MSB nibble decides: `a`=16'h9000, `b`=16'h8FFF → `done` at T+2 with `a_greater_b`=1.
  - Also `a`=16'h0000, `b`=16'hFFFF → `done` at T+2 with `a_lesser_b`=1.
- Mid nibble decides: `a`=16'h12A4, `b`=16'h12B0 → `done` at T+4 (nibbles 3 and 2 equal, nibble 1 differs) with `a_lesser_b`=1; flags then hold until the next accepted `start`.
- Handshake checks:
  - Pulse `start` with `a`=16'hFFFF during CMP of a 16'h1234-vs-16'h1234 compare → ignored; the original compare still ends `a_equal_b`=1 at T+5.
  - Raise `start` in the DONE cycle → accepted, and the flags clear on the next edge.
- Reset mid-op: start `a`=`b`=16'h5555 and assert `rst` at T+2 → next cycle all outputs 0 and state IDLE; no `done` pulse ever appears for that compare.
- Parameter corner: NIBBLES=1, `a`=4'h7, `b`=4'h7 → `done` at T+2 with `a_equal_b`=1.
